// File: rtl/boot_rom_mp.sv
// Multi-port boot ROM: round-robin arbitration of N_PORTS requesters onto one generic_rom macro.
// Optional patch table is built only when BOOT_ROM_PATCH_EN is defined.

// Synchronous-read ROM macro model. The image is a fixed pattern with a marker word at index 1.
module generic_rom #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  cen,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] q
);

  function automatic logic [31:0] rom_image(input logic [ADDR_WIDTH-1:0] a);
    logic [15:0] w;
    w = 16'(a);
    if (a == ADDR_WIDTH'(1)) return 32'h1111_2222;
    return {w ^ 16'hA5A5, w};
  endfunction

  always_ff @(posedge clk) begin
    if (!cen) q <= {(DATA_WIDTH/32){rom_image(addr)}};
  end

endmodule

module boot_rom_mp #(
  parameter int                    N_PORTS        = 2,
  parameter int                    ROM_ADDR_WIDTH = 13,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ROM_WORDS      = 2048,
  parameter int                    OUT_REG        = 0,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 'hDEAD_BEEF,
  parameter int                    N_PATCH        = 4,
  localparam int                   PIW            = (N_PATCH > 1) ? $clog2(N_PATCH) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             init_ni,
  input  logic                             test_mode_i,
  input  logic [N_PORTS-1:0]               req_i,
  input  logic [N_PORTS*ROM_ADDR_WIDTH-1:0] addr_i,
  output logic [N_PORTS-1:0]               gnt_o,
  output logic [N_PORTS-1:0]               rvalid_o,
  output logic [N_PORTS*DATA_WIDTH-1:0]    rdata_o,
  output logic [N_PORTS-1:0]               err_o,
  input  logic                             patch_we_i,
  input  logic [PIW-1:0]                   patch_idx_i,
  input  logic                             patch_valid_i,
  input  logic [ROM_ADDR_WIDTH-1:0]        patch_addr_i,
  input  logic [DATA_WIDTH-1:0]            patch_data_i
);

  localparam int WBYTES = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(WBYTES);
  localparam int WAW    = ROM_ADDR_WIDTH - OFF;
  localparam int RAW    = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
  localparam int PW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [PW-1:0]             rr_ptr;
  logic                      gnt_any;
  logic [PW-1:0]             gnt_idx;
  logic [ROM_ADDR_WIDTH-1:0] sel_addr;
  logic [WAW-1:0]            sel_word;
  logic                      in_range;
  logic                      rom_cen;
  logic [RAW-1:0]            rom_addr;
  logic [DATA_WIDTH-1:0]     rom_q;
  logic                      hit;
  logic [DATA_WIDTH-1:0]     hit_data;
  logic                      unused_bits;

  logic                      s1_valid;
  logic [PW-1:0]             s1_port;
  logic                      s1_err;
  logic                      s1_hit;
  logic [DATA_WIDTH-1:0]     s1_patch_data;
  logic [DATA_WIDTH-1:0]     s1_data;

  // Round-robin search from rr_ptr; no grant at all while reset or flush is active.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_o   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (init_ni && rst_ni) begin
      for (int i = 0; i < N_PORTS; i++) begin
        cand = (int'(rr_ptr) + i) % N_PORTS;
        if (!gnt_any && req_i[cand]) begin
          gnt_any     = 1'b1;
          gnt_idx     = PW'(cand);
          gnt_o[cand] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (!init_ni) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= PW'((int'(gnt_idx) + 1) % N_PORTS);
    end
  end

  assign sel_addr = addr_i[int'(gnt_idx)*ROM_ADDR_WIDTH +: ROM_ADDR_WIDTH];
  assign sel_word = sel_addr[ROM_ADDR_WIDTH-1:OFF];
  assign in_range = int'(sel_word) < ROM_WORDS;
  assign rom_cen  = !(gnt_any && in_range);
  assign rom_addr = sel_word[RAW-1:0];

  generic_rom #(
    .ADDR_WIDTH (RAW),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rom (
    .clk  (clk_i),
    .cen  (rom_cen),
    .addr (rom_addr),
    .q    (rom_q)
  );

`ifdef BOOT_ROM_PATCH_EN
  logic                  patch_valid [N_PATCH];
  logic [WAW-1:0]        patch_word  [N_PATCH];
  logic [DATA_WIDTH-1:0] patch_data  [N_PATCH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_PATCH; i++) begin
        patch_valid[i] <= 1'b0;
        patch_word[i]  <= '0;
        patch_data[i]  <= '0;
      end
    end else if (patch_we_i && (int'(patch_idx_i) < N_PATCH)) begin
      patch_valid[patch_idx_i] <= patch_valid_i;
      patch_word[patch_idx_i]  <= patch_addr_i[ROM_ADDR_WIDTH-1:OFF];
      patch_data[patch_idx_i]  <= patch_data_i;
    end
  end

  // Scanning downwards lets the lowest matching index have the final say.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = N_PATCH - 1; i >= 0; i--) begin
      if (patch_valid[i] && (patch_word[i] == sel_word)) begin
        hit      = 1'b1;
        hit_data = patch_data[i];
      end
    end
    if (test_mode_i) hit = 1'b0;
  end

  assign unused_bits = ^{addr_i, patch_addr_i};
`else
  assign hit         = 1'b0;
  assign hit_data    = '0;
  assign unused_bits = ^{addr_i, test_mode_i, patch_we_i, patch_idx_i,
                         patch_valid_i, patch_addr_i, patch_data_i};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid      <= 1'b0;
      s1_port       <= '0;
      s1_err        <= 1'b0;
      s1_hit        <= 1'b0;
      s1_patch_data <= '0;
    end else if (!init_ni) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= gnt_any;
      if (gnt_any) begin
        s1_port       <= gnt_idx;
        s1_err        <= !in_range && !hit;
        s1_hit        <= hit;
        s1_patch_data <= hit_data;
      end
    end
  end

  assign s1_data = s1_hit ? s1_patch_data : (s1_err ? ERR_DATA : rom_q);

  // Response valids are masked by init_ni so a flush also swallows a response in its final cycle.
  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    if (OUT_REG == 0) begin : g_direct
      logic                  fire;
      logic [DATA_WIDTH-1:0] hold_data;
      logic                  hold_err;

      assign fire = s1_valid && init_ni && (s1_port == PW'(p));

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          hold_data <= '0;
          hold_err  <= 1'b0;
        end else if (fire) begin
          hold_data <= s1_data;
          hold_err  <= s1_err;
        end
      end

      assign rvalid_o[p]                       = fire;
      assign rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = fire ? s1_data : hold_data;
      assign err_o[p]                          = fire ? s1_err : hold_err;
    end else begin : g_registered
      logic                  out_valid;
      logic [DATA_WIDTH-1:0] out_data;
      logic                  out_err;
      logic                  take;

      assign take = s1_valid && (s1_port == PW'(p));

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          out_valid <= 1'b0;
          out_data  <= '0;
          out_err   <= 1'b0;
        end else if (!init_ni) begin
          out_valid <= 1'b0;
        end else begin
          out_valid <= take;
          if (take) begin
            out_data <= s1_data;
            out_err  <= s1_err;
          end
        end
      end

      assign rvalid_o[p]                       = out_valid && init_ni;
      assign rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = out_data;
      assign err_o[p]                          = out_err;
    end
  end

endmodule

// File: tb/tb_boot_rom_mp.sv
// Directed bench for boot_rom_mp (2 ports, 1024 words, no output register).
// Patch expectations follow BOOT_ROM_PATCH_EN when it is defined for the build.
module tb_boot_rom_mp;

`ifdef BOOT_ROM_PATCH_EN
  localparam bit PATCH = 1'b1;
`else
  localparam bit PATCH = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        init_n;
  logic        test_mode;
  logic [1:0]  req;
  logic [25:0] addr;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [63:0] rdata;
  logic [1:0]  err;
  logic        patch_we;
  logic [1:0]  patch_idx;
  logic        patch_valid;
  logic [12:0] patch_addr;
  logic [31:0] patch_data;

  int tests    = 0;
  int failures = 0;

  boot_rom_mp #(
    .N_PORTS        (2),
    .ROM_ADDR_WIDTH (13),
    .DATA_WIDTH     (32),
    .ROM_WORDS      (1024),
    .OUT_REG        (0),
    .ERR_DATA       (32'hDEAD_BEEF),
    .N_PATCH        (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .init_ni       (init_n),
    .test_mode_i   (test_mode),
    .req_i         (req),
    .addr_i        (addr),
    .gnt_o         (gnt),
    .rvalid_o      (rvalid),
    .rdata_o       (rdata),
    .err_o         (err),
    .patch_we_i    (patch_we),
    .patch_idx_i   (patch_idx),
    .patch_valid_i (patch_valid),
    .patch_addr_i  (patch_addr),
    .patch_data_i  (patch_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic after_rise();
    @(posedge clk);
    #1;
  endtask

  task automatic after_fall();
    @(negedge clk);
    #1;
  endtask

  task automatic write_patch(input logic [1:0] idx, input logic [12:0] a, input logic [31:0] d);
    @(negedge clk);
    patch_we    = 1'b1;
    patch_idx   = idx;
    patch_valid = 1'b1;
    patch_addr  = a;
    patch_data  = d;
    after_rise();
    patch_we = 1'b0;
  endtask

  task automatic read_port0(input logic [12:0] a);
    @(negedge clk);
    req        = 2'b01;
    addr[12:0] = a;
    after_rise();
    req = 2'b00;
  endtask

  initial begin
    rst_n       = 1'b0;
    init_n      = 1'b1;
    test_mode   = 1'b0;
    req         = 2'b11;
    addr        = '0;
    patch_we    = 1'b0;
    patch_idx   = '0;
    patch_valid = 1'b0;
    patch_addr  = '0;
    patch_data  = '0;

    // Reset state, with both requests high to show grants are suppressed
    #12;
    check_output("reset_gnt", gnt, 2'b00);
    check_output("reset_rvalid", rvalid, 2'b00);
    check_output("reset_err", err, 2'b00);
    check_output("reset_rdata", rdata, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 2'b00;

    // T1: single read of word 1
    @(negedge clk);
    req        = 2'b01;
    addr[12:0] = 13'h0004;
    #1;
    check_output("t1_gnt", gnt, 2'b01);
    after_rise();
    req = 2'b00;
    check_output("t1_rvalid", rvalid, 2'b01);
    check_output("t1_rdata", rdata[31:0], 32'h1111_2222);
    check_output("t1_err", err[0], 1'b0);
    after_rise();
    check_output("t1_rvalid_pulse", rvalid, 2'b00);
    check_output("t1_rdata_hold", rdata[31:0], 32'h1111_2222);

    // T2: both ports stream; pointer sits at port 1 after T1
    req         = 2'b11;
    addr[12:0]  = 13'h0008;
    addr[25:13] = 13'h000C;
    for (int k = 0; k < 4; k++) begin
      after_fall();
      check_output("t2_gnt", gnt, (k % 2 == 0) ? 2'b10 : 2'b01);
      after_rise();
      check_output("t2_rvalid", rvalid, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k % 2 == 0) check_output("t2_rdata1", rdata[63:32], 32'hA5A6_0003);
      else            check_output("t2_rdata0", rdata[31:0], 32'hA5A7_0002);
    end
    req = 2'b00;
    after_rise();
    check_output("t2_no_extra_rvalid", rvalid, 2'b00);

    // T3: out-of-range word 2047
    @(negedge clk);
    req        = 2'b01;
    addr[12:0] = 13'h1FFC;
    #1;
    check_output("t3_gnt", gnt, 2'b01);
    check_output("t3_rom_cen", dut.rom_cen, 1'b1);
    after_rise();
    req = 2'b00;
    check_output("t3_rvalid", rvalid, 2'b01);
    check_output("t3_rdata", rdata[31:0], PATCH ? 32'hDEAD_BEEF : 32'hDEAD_BEEF);
    check_output("t3_err", err[0], 1'b1);

    // T4: flush right after a grant to port 1
    @(negedge clk);
    req         = 2'b10;
    addr[25:13] = 13'h0004;
    #1;
    check_output("t4_gnt1", gnt, 2'b10);
    after_rise();
    init_n     = 1'b0;
    req        = 2'b11;
    addr[12:0] = 13'h0004;
    #1;
    check_output("t4_flush_gnt", gnt, 2'b00);
    check_output("t4_flush_rvalid", rvalid, 2'b00);
    check_output("t4_flush_rdata1", rdata[63:32], 32'hA5A6_0003);
    after_rise();
    init_n = 1'b1;
    #1;
    check_output("t4_post_rvalid", rvalid, 2'b00);
    check_output("t4_post_gnt", gnt, 2'b01);
    after_rise();
    req = 2'b00;
    check_output("t4_rvalid0", rvalid, 2'b01);
    check_output("t4_rdata0", rdata[31:0], 32'h1111_2222);
    check_output("t4_rdata1_hold", rdata[63:32], 32'hA5A6_0003);

    // T5: patch table
    write_patch(2'd0, 13'h0010, 32'hCAFE_F00D);
    read_port0(13'h0010);
    check_output("t5_patch_rvalid", rvalid, 2'b01);
    check_output("t5_patch_rdata", rdata[31:0], PATCH ? 32'hCAFE_F00D : 32'hA5A1_0004);
    check_output("t5_patch_err", err[0], 1'b0);
    test_mode = 1'b1;
    read_port0(13'h0010);
    check_output("t5_bypass_rdata", rdata[31:0], 32'hA5A1_0004);
    test_mode = 1'b0;

    @(negedge clk);
    patch_we    = 1'b1;
    patch_idx   = 2'd1;
    patch_valid = 1'b1;
    patch_addr  = 13'h0014;
    patch_data  = 32'h1234_5678;
    req         = 2'b01;
    addr[12:0]  = 13'h0014;
    after_rise();
    patch_we = 1'b0;
    req      = 2'b00;
    check_output("t5_same_cycle_old", rdata[31:0], 32'hA5A0_0005);
    read_port0(13'h0014);
    check_output("t5_same_cycle_new", rdata[31:0], PATCH ? 32'h1234_5678 : 32'hA5A0_0005);

    write_patch(2'd2, 13'h1FFC, 32'h0BAD_C0DE);
    read_port0(13'h1FFC);
    check_output("t5_oor_rdata", rdata[31:0], PATCH ? 32'h0BAD_C0DE : 32'hDEAD_BEEF);
    check_output("t5_oor_err", err[0], PATCH ? 1'b0 : 1'b1);

    write_patch(2'd3, 13'h0010, 32'h7777_8888);
    read_port0(13'h0010);
    check_output("t5_lowest_idx", rdata[31:0], PATCH ? 32'hCAFE_F00D : 32'hA5A1_0004);

    // T6: reset while a response is on the bus, then while a grant is outstanding
    read_port0(13'h0008);
    check_output("t6_rvalid_before", rvalid, 2'b01);
    rst_n = 1'b0;
    #1;
    check_output("t6_rvalid_drop", rvalid, 2'b00);
    check_output("t6_rdata_reset", rdata[31:0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    after_rise();
    check_output("t6_no_stale1", rvalid, 2'b00);

    @(negedge clk);
    req        = 2'b01;
    addr[12:0] = 13'h0004;
    #1;
    check_output("t6_gnt", gnt, 2'b01);
    rst_n = 1'b0;
    #1;
    check_output("t6_gnt_in_reset", gnt, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 2'b00;
    after_rise();
    check_output("t6_no_stale2", rvalid, 2'b00);
    after_rise();
    check_output("t6_no_stale3", rvalid, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
